// File: rtl/dvp_tx.sv
// DVP camera-bus transmitter: streams an RGB565 framebuffer as vsync/href/byte timing.
// Define DVP_TX_PATTERN_EN to add i_pattern, which selects a built-in 8-bar colour pattern.
module dvp_tx #(
    parameter int P_WIDTH       = 160,
    parameter int P_HEIGHT      = 120,
    parameter int P_HBLANK      = 144,
    parameter int P_VSYNC_LINES = 3,
    parameter int P_VBP_LINES   = 17,
    parameter int P_VFP_LINES   = 10
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic                                   i_enable,
`ifdef DVP_TX_PATTERN_EN
    input  logic                                   i_pattern,
`endif
    output logic                                   o_rd_req,
    output logic [$clog2(P_WIDTH*P_HEIGHT)-1:0]    o_rd_addr,
    input  logic [15:0]                            i_rd_data,
    output logic                                   o_vsync,
    output logic                                   o_href,
    output logic [7:0]                             o_data,
    output logic                                   o_frame_done,
    output logic                                   o_busy
);

    localparam int L  = 2*P_WIDTH + P_HBLANK;
    localparam int AW = $clog2(P_WIDTH*P_HEIGHT);
    localparam int HW = $clog2(L);
    localparam int VW = $clog2(P_VSYNC_LINES + P_VBP_LINES + P_HEIGHT + P_VFP_LINES + 1);

    localparam logic [HW-1:0] HC_LAST     = HW'(L-1);
    localparam logic [HW-1:0] HC_PRE      = HW'(L-2);
    localparam logic [HW-1:0] HC_RD_END   = HW'(2*P_WIDTH-2);
    localparam logic [HW-1:0] HC_HREF_END = HW'(2*P_WIDTH);

    typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

    state_t          state_reg, state_next;
    logic [HW-1:0]   hcnt_reg, hcnt_next;
    logic [VW-1:0]   vcnt_reg, vcnt_next;
    logic [VW-1:0]   state_lines;
    logic [AW-1:0]   addr_reg, addr_next;
    logic [7:0]      lo_reg, lo_next;
    logic [7:0]      data_next;
    logic            line_end, last_line;
    logic            rd_fire, rd_gate, href_next;
    logic [15:0]     pixel_word;

    always_comb begin
        state_next = state_reg;
        hcnt_next  = hcnt_reg;
        vcnt_next  = vcnt_reg;
        line_end   = (hcnt_reg == HC_LAST);
        case (state_reg)
            VSYNC:   state_lines = VW'(P_VSYNC_LINES);
            VBP:     state_lines = VW'(P_VBP_LINES);
            ACTIVE:  state_lines = VW'(P_HEIGHT);
            VFP:     state_lines = VW'(P_VFP_LINES);
            default: state_lines = VW'(1);
        endcase
        last_line = (vcnt_reg == state_lines - VW'(1));

        if (state_reg == IDLE) begin
            hcnt_next = '0;
            vcnt_next = '0;
            if (i_enable) state_next = VSYNC;
        end else begin
            hcnt_next = line_end ? '0 : hcnt_reg + HW'(1);
            if (line_end) begin
                if (last_line) begin
                    vcnt_next = '0;
                    case (state_reg)
                        VSYNC:   state_next = VBP;
                        VBP:     state_next = ACTIVE;
                        ACTIVE:  state_next = VFP;
                        default: state_next = i_enable ? VSYNC : IDLE;
                    endcase
                end else begin
                    vcnt_next = vcnt_reg + VW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
            hcnt_reg  <= '0;
            vcnt_reg  <= '0;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            hcnt_reg  <= hcnt_next;
            vcnt_reg  <= vcnt_next;
            addr_reg  <= addr_next;
        end
    end

`ifdef DVP_TX_PATTERN_EN
    localparam int BW = P_WIDTH / 8;
    localparam logic [15:0] BAR_RGB [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    logic        pattern_reg;
    logic [7:1]  bar_ge;
    logic [15:0] bar_word;

    // Pattern mode is frozen for the whole frame at the VSYNC entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pattern_reg <= 1'b0;
        end else if (state_next == VSYNC && state_reg != VSYNC) begin
            pattern_reg <= i_pattern;
        end
    end

    for (genvar gi = 1; gi < 8; gi++) begin : g_bar
        assign bar_ge[gi] = (hcnt_reg >= HW'(2*gi*BW));
    end

    always_comb begin
        bar_word = BAR_RGB[0];
        for (int i = 1; i < 8; i++) begin
            if (bar_ge[i]) bar_word = BAR_RGB[i];
        end
    end

    assign pixel_word = pattern_reg ? bar_word : i_rd_data;
    assign rd_gate    = ~pattern_reg;
`else
    assign pixel_word = i_rd_data;
    assign rd_gate    = 1'b1;
`endif

    // Reads run two cycles ahead of the high byte, so the first read of a line
    // falls in the tail of the previous line (or of the last back-porch line).
    always_comb begin
        rd_fire = 1'b0;
        if (state_reg == ACTIVE) begin
            rd_fire = (!hcnt_reg[0] && hcnt_reg < HC_RD_END) ||
                      (hcnt_reg == HC_PRE && !last_line);
        end else if (state_reg == VBP) begin
            rd_fire = last_line && (hcnt_reg == HC_PRE);
        end

        addr_next = addr_reg;
        if (state_reg == VSYNC) begin
            addr_next = '0;
        end else if (rd_fire) begin
            addr_next = addr_reg + AW'(1);
        end

        href_next = (state_reg == ACTIVE) && (hcnt_reg < HC_HREF_END);
        data_next = 8'h00;
        lo_next   = lo_reg;
        if (href_next) begin
            if (!hcnt_reg[0]) begin
                data_next = pixel_word[15:8];
                lo_next   = pixel_word[7:0];
            end else begin
                data_next = lo_reg;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_vsync      <= 1'b0;
            o_href       <= 1'b0;
            o_data       <= 8'h00;
            lo_reg       <= 8'h00;
            o_rd_req     <= 1'b0;
            o_rd_addr    <= '0;
            o_frame_done <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_vsync      <= (state_reg == VSYNC);
            o_href       <= href_next;
            o_data       <= data_next;
            lo_reg       <= lo_next;
            o_rd_req     <= rd_fire & rd_gate;
            if (rd_fire & rd_gate) o_rd_addr <= addr_reg;
            o_frame_done <= (state_reg == VFP) && line_end && last_line;
            o_busy       <= (state_reg != IDLE);
        end
    end

endmodule
